// File: rtl/qe_w5300_bus_ctrl_if.sv
// QL expansion bus / W5300 signal bundle seen by the bus-cycle controller.
// The slave modport is the controller; the master modport is the QL/W5300 side.
interface qe_w5300_bus_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int CS_N   = 2
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        sp;
  logic              asl;
  logic              dsl;
  logic              rdwl;
  logic              dtackl;
  logic              dsmcl;
  logic              dbenl;
  logic              dbdir;
  logic [CS_N-1:0]   wizcsl;
  logic              wizrdl;
  logic              wizwrl;
  logic              wizrstl;

  modport master (
    output address, sp, asl, dsl, rdwl,
    input  dtackl, dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl
  );

  modport slave (
    input  address, sp, asl, dsl, rdwl,
    output dtackl, dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl
  );
endinterface

// File: rtl/qe_w5300_bus_ctrl.sv
// 68008 (QL expansion bus) to W5300 bus-cycle controller: decode, wait-stated
// strobes, DTACK/DSMC/buffer control and the W5300 hardware-reset pulse.
module qe_w5300_bus_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int CS_N    = 2,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 2,
  parameter int RECOVER = 2,
  parameter int RST_LEN = 16
) (
  input logic                clk,
  input logic                rst,
  qe_w5300_bus_ctrl_if.slave bus
);
  localparam int CSB   = (CS_N > 1) ? $clog2(CS_N) : 0;
  localparam int CHW   = (CSB > 0) ? CSB : 1;
  localparam int MID_W = ADDR_W - 4 - CSB;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_DTACK   = 3'd2;
  localparam logic [2:0] S_CTRL    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [3:0]       slot;
  logic [MID_W-1:0] mid;
  logic [CHW-1:0]   ch_in;
  logic             dev_hit, ctl_hit;

  assign slot = bus.address[ADDR_W-1 -: 4];
  assign mid  = bus.address[ADDR_W-5 -: MID_W];

  if (CSB > 0) begin : g_ch
    assign ch_in = bus.address[CSB-1:0];
  end else begin : g_no_ch
    assign ch_in = 1'b0;
  end

  assign dev_hit = (slot == bus.sp) && (mid == '0);
  assign ctl_hit = (slot == bus.sp) && (&mid) && !bus.rdwl;

  // A floating address gives an X condition, which takes the else path: no hit.
  always_comb begin
    bus.dsmcl = 1'b1;
    if (!rst && !bus.asl && (dev_hit || ctl_hit)) bus.dsmcl = 1'b0;
  end

  logic [1:0]      asl_sync_q, dsl_sync_q;
  logic            asl_s, dsl_s;
  logic [2:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [7:0]      rst_cnt_q, rst_cnt_d;
  logic            ctl_start;
  logic            dtackl_q, dtackl_d, dbenl_q, dbenl_d, dbdir_q, dbdir_d;
  logic            rdl_q, rdl_d, wrl_q, wrl_d, rstl_q, rstl_d;
  logic [CS_N-1:0] cs_q, cs_d;

  assign asl_s = asl_sync_q[1];
  assign dsl_s = dsl_sync_q[1];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    ch_d      = ch_q;
    ctl_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!asl_s && !dsl_s) begin
          if (dev_hit) begin
            state_d = S_ACCESS;
            rd_d    = bus.rdwl;
            ch_d    = ch_in;
            cnt_d   = bus.rdwl ? 4'(RD_WAIT - 1) : 4'(WR_WAIT - 1);
          end else if (ctl_hit) begin
            state_d   = S_CTRL;
            ctl_start = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (asl_s || dsl_s) begin
          state_d = S_RECOVER;
          cnt_d   = 4'(RECOVER - 1);
        end else if (cnt_q == 4'd0) begin
          state_d = S_DTACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DTACK, S_CTRL: begin
        if (dsl_s) begin
          state_d = S_RECOVER;
          cnt_d   = 4'(RECOVER - 1);
        end
      end
      S_RECOVER: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (asl_s)    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (ctl_start)              rst_cnt_d = 8'(RST_LEN);
    else if (rst_cnt_q != 8'd0) rst_cnt_d = rst_cnt_q - 8'd1;
    else                        rst_cnt_d = 8'd0;
    rstl_d = (rst_cnt_d == 8'd0);
  end

  // Outputs are decoded from the next state so each one leaves a flop.
  always_comb begin
    cs_d     = '1;
    dtackl_d = 1'b1;
    dbenl_d  = 1'b1;
    dbdir_d  = 1'b0;
    rdl_d    = 1'b1;
    wrl_d    = 1'b1;
    case (state_d)
      S_ACCESS: begin
        cs_d[ch_d] = 1'b0;
        dbenl_d    = 1'b0;
        dbdir_d    = rd_d;
        rdl_d      = !rd_d;
        wrl_d      = rd_d;
      end
      S_DTACK: begin
        cs_d[ch_d] = 1'b0;
        dtackl_d   = 1'b0;
        dbenl_d    = 1'b0;
        dbdir_d    = rd_d;
        rdl_d      = !rd_d;
      end
      S_CTRL:  dtackl_d = 1'b0;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      asl_sync_q <= 2'b11;
      dsl_sync_q <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      ch_q       <= '0;
      rst_cnt_q  <= 8'(RST_LEN);
      rstl_q     <= 1'b0;
      cs_q       <= '1;
      dtackl_q   <= 1'b1;
      dbenl_q    <= 1'b1;
      dbdir_q    <= 1'b0;
      rdl_q      <= 1'b1;
      wrl_q      <= 1'b1;
    end else begin
      asl_sync_q <= {asl_sync_q[0], bus.asl};
      dsl_sync_q <= {dsl_sync_q[0], bus.dsl};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      ch_q       <= ch_d;
      rst_cnt_q  <= rst_cnt_d;
      rstl_q     <= rstl_d;
      cs_q       <= cs_d;
      dtackl_q   <= dtackl_d;
      dbenl_q    <= dbenl_d;
      dbdir_q    <= dbdir_d;
      rdl_q      <= rdl_d;
      wrl_q      <= wrl_d;
    end
  end

  assign bus.dtackl  = dtackl_q;
  assign bus.dbenl   = dbenl_q;
  assign bus.dbdir   = dbdir_q;
  assign bus.wizcsl  = cs_q;
  assign bus.wizrdl  = rdl_q;
  assign bus.wizwrl  = wrl_q;
  assign bus.wizrstl = rstl_q;
endmodule

// File: tb/tb_qe_w5300_bus_ctrl.sv
// Bench for qe_w5300_bus_ctrl: directed bus cycles checked every cycle against
// an edge-window model of the timing rules, plus literal timing expectations.
module tb_qe_w5300_bus_ctrl;
  localparam int ADDR_W  = 10;
  localparam int CS_N    = 2;
  localparam int CSB     = 1;
  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 2;
  localparam int RECOVER = 2;
  localparam int RST_LEN = 16;
  localparam int MID_ONES = (1 << (ADDR_W - 4 - CSB)) - 1;
  localparam int NEVER    = 1 << 30;

  typedef enum int {TX_NONE, TX_RD, TX_WR, TX_CTL} tx_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qe_w5300_bus_ctrl_if #(.ADDR_W(ADDR_W), .CS_N(CS_N)) bus ();

  qe_w5300_bus_ctrl #(
    .ADDR_W(ADDR_W), .CS_N(CS_N), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT),
    .RECOVER(RECOVER), .RST_LEN(RST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  rst_last = -1000;
  bit  cmp_en = 1'b0;

  // Current transaction, in edge numbers: E0 first low sample, F0 first dsl=1 sample,
  // kill = edge sampling rst high mid-cycle.
  tx_e tx_kind = TX_NONE;
  int  tx_ch = 0;
  int  tx_e0 = -1000;
  int  tx_f0 = NEVER;
  int  tx_kill = NEVER;
  int  ctl_reload = -1000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_last <= cyc + 1;
  end

  function automatic logic exp_dsmcl(input logic r, input logic a,
                                     input logic [ADDR_W-1:0] ad,
                                     input logic [3:0] s, input logic rw);
    int slot, mid;
    slot = int'(ad) >> (ADDR_W - 4);
    mid  = (int'(ad) >> CSB) % (MID_ONES + 1);
    return !(!r && !a && slot == int'(s) && (mid == 0 || (mid == MID_ONES && !rw)));
  endfunction

  always @(negedge clk) begin : compare
    int n, start, stop, w, base;
    logic act, dt, xfer;
    logic [CS_N-1:0] ecs;
    if (cmp_en) begin
      n     = cyc;
      start = tx_e0 + 2;
      stop  = (tx_f0 + 2 < tx_kill) ? tx_f0 + 2 : tx_kill;
      act   = (tx_kind != TX_NONE) && n >= start && n < stop;
      xfer  = act && (tx_kind == TX_RD || tx_kind == TX_WR);
      w     = (tx_kind == TX_RD) ? RD_WAIT : WR_WAIT;
      dt    = (tx_kind == TX_CTL) ? act : (xfer && n >= start + w);
      ecs   = '1;
      if (xfer) ecs[tx_ch] = 1'b0;
      base = rst_last;
      if (ctl_reload <= n && ctl_reload > base) base = ctl_reload;
      check("cmp_dtackl", 8'(bus.dtackl), 8'(!dt));
      check("cmp_wizcsl", 8'(bus.wizcsl), 8'(ecs));
      check("cmp_wizrdl", 8'(bus.wizrdl), 8'(!(xfer && tx_kind == TX_RD)));
      check("cmp_wizwrl", 8'(bus.wizwrl), 8'(!(xfer && tx_kind == TX_WR && n < start + w)));
      check("cmp_dbenl", 8'(bus.dbenl), 8'(!xfer));
      check("cmp_dbdir", 8'(bus.dbdir), 8'(xfer && tx_kind == TX_RD));
      check("cmp_wizrstl", 8'(bus.wizrstl), 8'(n >= base + RST_LEN));
      check("cmp_dsmcl", 8'(bus.dsmcl),
            8'(exp_dsmcl(rst, bus.asl, bus.address, bus.sp, bus.rdwl)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic start_tx(input tx_e kind, input logic [ADDR_W-1:0] addr, input logic rw);
    tx_kind = kind;
    tx_ch   = int'(addr) % CS_N;
    tx_e0   = cyc + 1;
    tx_f0   = NEVER;
    tx_kill = NEVER;
    if (kind == TX_CTL) ctl_reload = tx_e0 + 2;
    bus.address = addr;
    bus.rdwl    = rw;
    bus.asl     = 1'b0;
    bus.dsl     = 1'b0;
  endtask

  task automatic end_tx();
    if (tx_f0 == NEVER) tx_f0 = cyc + 1;
    bus.dsl = 1'b1;
    bus.asl = 1'b1;
  endtask

  int e0, f0, r, cnt, k, wr_low, wr_rise, dt_fall, bad_dt, bad_act;
  logic prev_wr;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.address = '0;
    bus.sp      = 4'd1;
    bus.asl     = 1'b1;
    bus.dsl     = 1'b1;
    bus.rdwl    = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    check("rst_dtackl", 8'(bus.dtackl), 8'h1);
    check("rst_dsmcl", 8'(bus.dsmcl), 8'h1);
    check("rst_dbenl", 8'(bus.dbenl), 8'h1);
    check("rst_dbdir", 8'(bus.dbdir), 8'h0);
    check("rst_wizcsl", 8'(bus.wizcsl), 8'h3);
    check("rst_wizrdl", 8'(bus.wizrdl), 8'h1);
    check("rst_wizwrl", 8'(bus.wizwrl), 8'h1);
    check("rst_wizrstl", 8'(bus.wizrstl), 8'h0);

    // Power-up pulse length.
    rst = 1'b0;
    cnt = 0;
    while (bus.wizrstl !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    check("powerup_pulse_len", 8'(cnt), 8'd16);
    repeat (4) tick();

    // Read, channel 0 (slot 1, mid 0).
    start_tx(TX_RD, 10'h040, 1'b1);
    e0 = tx_e0;
    go_to(e0 + 1);
    check("rd_dsmcl_hit", 8'(bus.dsmcl), 8'h0);
    check("rd_cs_before_e2", 8'(bus.wizcsl), 8'h3);
    go_to(e0 + 2);
    check("rd_cs_e2", 8'(bus.wizcsl), 8'h2);
    check("rd_wizrdl_e2", 8'(bus.wizrdl), 8'h0);
    check("rd_dbdir_e2", 8'(bus.dbdir), 8'h1);
    check("rd_dbenl_e2", 8'(bus.dbenl), 8'h0);
    go_to(e0 + 4);
    check("rd_dtackl_e4", 8'(bus.dtackl), 8'h1);
    go_to(e0 + 5);
    check("rd_dtackl_e5", 8'(bus.dtackl), 8'h0);
    go_to(e0 + 7);
    end_tx();
    f0 = tx_f0;
    go_to(f0 + 1);
    check("rd_dtackl_f1", 8'(bus.dtackl), 8'h0);
    go_to(f0 + 2);
    check("rd_dtackl_f2", 8'(bus.dtackl), 8'h1);
    check("rd_cs_f2", 8'(bus.wizcsl), 8'h3);
    check("rd_wizrdl_f2", 8'(bus.wizrdl), 8'h1);
    repeat (6) tick();

    // Write, channel 1.
    start_tx(TX_WR, 10'h041, 1'b0);
    e0 = tx_e0;
    wr_low = 0; wr_rise = -1; dt_fall = -1; prev_wr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      go_to(e0 + i);
      if (!bus.wizwrl) wr_low++;
      if (bus.wizwrl && !prev_wr && wr_rise < 0) wr_rise = i;
      if (!bus.dtackl && dt_fall < 0) dt_fall = i;
      if (i == 3) begin
        check("wr_cs", 8'(bus.wizcsl), 8'h1);
        check("wr_dbdir", 8'(bus.dbdir), 8'h0);
      end
      prev_wr = bus.wizwrl;
    end
    check("wr_strobe_len", 8'(wr_low), 8'd2);
    check("wr_rise_edge", 8'(wr_rise), 8'd4);
    check("wr_dtack_edge", 8'(dt_fall), 8'd4);
    end_tx();
    repeat (6) tick();

    // Non-matching slot, then a read of the control address: no hit.
    start_tx(TX_NONE, 10'h080, 1'b1);
    tick();
    check("miss_dsmcl", 8'(bus.dsmcl), 8'h1);
    repeat (8) tick();
    check("miss_dtackl", 8'(bus.dtackl), 8'h1);
    check("miss_cs", 8'(bus.wizcsl), 8'h3);
    end_tx();
    repeat (4) tick();
    start_tx(TX_NONE, 10'h07E, 1'b1);
    tick();
    check("ctlrd_dsmcl", 8'(bus.dsmcl), 8'h1);
    repeat (8) tick();
    check("ctlrd_dtackl", 8'(bus.dtackl), 8'h1);
    check("ctlrd_cs", 8'(bus.wizcsl), 8'h3);
    end_tx();
    repeat (6) tick();

    // Abort: dsl released one clock into ACCESS, then re-asserted with asl still low.
    start_tx(TX_RD, 10'h040, 1'b1);
    e0 = tx_e0;
    go_to(e0 + 2);
    tx_f0 = cyc + 1;
    bus.dsl = 1'b1;
    bad_dt = 0; bad_act = 0;
    for (int i = 3; i <= 14; i++) begin
      go_to(e0 + i);
      if (i == 7) bus.dsl = 1'b0;
      if (!bus.dtackl) bad_dt++;
      if (i >= 5 && bus.wizcsl != 2'b11) bad_act++;
    end
    check("abort_no_dtack", 8'(bad_dt), 8'd0);
    check("abort_no_restart", 8'(bad_act), 8'd0);
    end_tx();
    repeat (6) tick();
    start_tx(TX_RD, 10'h041, 1'b1);
    e0 = tx_e0;
    go_to(e0 + 5);
    check("post_abort_dtackl", 8'(bus.dtackl), 8'h0);
    check("post_abort_cs", 8'(bus.wizcsl), 8'h1);
    end_tx();
    repeat (6) tick();

    // Control write at pulse clock 10 extends the pulse to 26 clocks.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    r = cyc;
    fork
      begin
        cnt = 0;
        while (bus.wizrstl !== 1'b1 && cnt < 100) begin tick(); cnt++; end
      end
      begin
        go_to(r + 7);
        start_tx(TX_CTL, 10'h07E, 1'b0);
        go_to(r + 10);
        check("ctl_dtackl", 8'(bus.dtackl), 8'h0);
        check("ctl_cs", 8'(bus.wizcsl), 8'h3);
        go_to(r + 12);
        end_tx();
      end
    join
    check("ctl_pulse_len", 8'(cnt), 8'd26);
    repeat (4) tick();

    // rst during DTACK of a read.
    start_tx(TX_RD, 10'h040, 1'b1);
    e0 = tx_e0;
    go_to(e0 + 6);
    check("rstmid_in_dtack", 8'(bus.dtackl), 8'h0);
    rst = 1'b1;
    tx_kill = cyc + 1;
    go_to(e0 + 7);
    check("rstmid_dtackl", 8'(bus.dtackl), 8'h1);
    check("rstmid_wizrdl", 8'(bus.wizrdl), 8'h1);
    check("rstmid_cs", 8'(bus.wizcsl), 8'h3);
    check("rstmid_wizrstl", 8'(bus.wizrstl), 8'h0);
    check("rstmid_dsmcl", 8'(bus.dsmcl), 8'h1);
    end_tx();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rstmid_pulse_done", 8'(bus.wizrstl), 8'h1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
